// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, single-outstanding imem request, IF/ID payload (optional FETCH_MISALIGN_TRAP_EN)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] new_pc_i,
    input  logic        redirect_i,
    output logic [31:0] cur_pc_o,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT = 3'd4
`endif
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [31:0] pc;
    logic [31:0] nxt_pc;
    logic        drop;
    logic        nxt_drop;
    logic        load_payload;

    always_comb begin
        nxt_state    = state;
        nxt_pc       = pc;
        nxt_drop     = drop;
        load_payload = 1'b0;
        case (state)
            IDLE: begin
                nxt_state = REQ;
                if (redirect_i) nxt_pc = new_pc_i;
            end
            REQ: begin
                if (redirect_i) begin
                    nxt_pc = new_pc_i;
                    // an accepted request for the old PC must have its response thrown away
                    if (imem_req_ready) begin
                        nxt_drop  = 1'b1;
                        nxt_state = WAIT;
                    end
                end else if (imem_req_ready) begin
                    nxt_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    nxt_state = REQ;
                    nxt_drop  = 1'b0;
                    if (redirect_i) begin
                        nxt_pc = new_pc_i;
                    end else if (!drop) begin
                        load_payload = 1'b1;
                        nxt_state    = HOLD;
                    end
                end else if (redirect_i) begin
                    nxt_pc   = new_pc_i;
                    nxt_drop = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i || if_ready) begin
                    nxt_pc    = new_pc_i;
                    nxt_state = REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
                if (redirect_i) begin
                    nxt_pc    = new_pc_i;
                    nxt_state = REQ;
                end
            end
`endif
            default: nxt_state = IDLE;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        // a misaligned PC never reaches memory
        if (nxt_state == REQ && nxt_pc[1:0] != 2'b00) nxt_state = FAULT;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            state <= nxt_state;
            pc    <= nxt_pc;
            drop  <= nxt_drop;
            if (load_payload) begin
                if_pc    <= pc;
                if_instr <= imem_resp_data;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            else if (nxt_state == FAULT) begin
                if_pc <= nxt_pc;
            end
`endif
        end
    end

    assign cur_pc_o       = pc;
    assign imem_req_valid = (state == REQ);
    assign if_valid       = (state == HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign imem_req_addr  = pc;
    assign fetch_fault_o  = (state == FAULT);
`else
    assign imem_req_addr  = {pc[31:2], 2'b00};
    assign fetch_fault_o  = 1'b0;
`endif

endmodule
